// File: rtl/omok_win_checker_if.sv
// Request/result bundle between the OMOK board core and the win checker.
//   start      : 1-cycle request carrying the placed stone
//   pos_h/v    : coordinates of the placed stone
//   color      : placed colour (01 black, 10 white)
//   board      : packed board, cell i = v*N+h at [2i+1:2i]
//   busy/done  : scan in progress / 1-cycle result strobe
//   win*       : held result of the last accepted request
interface omok_win_checker_if #(parameter int N = 10);
  logic               start;
  logic [3:0]         pos_h;
  logic [3:0]         pos_v;
  logic [1:0]         color;
  logic [2*N*N-1:0]   board;
  logic               busy;
  logic               done;
  logic               win;
  logic [1:0]         win_color;
  logic [1:0]         win_dir;

  modport master (output start, pos_h, pos_v, color, board,
                  input  busy, done, win, win_color, win_dir);
  modport slave  (input  start, pos_h, pos_v, color, board,
                  output busy, done, win, win_color, win_dir);
endinterface

// File: rtl/omok_win_checker.sv
// Sequential five-in-a-row judge. On an accepted start it snapshots the
// board and the placed stone, then walks the 4 line directions one cell per
// cycle (WIN_LEN-1 cells each way) and strobes done with the result after a
// fixed 8*(WIN_LEN-1)+1 cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : request/result bundle (slave side)
module omok_win_checker #(
  parameter int N       = 10,
  parameter int WIN_LEN = 5,
  parameter int EXACT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  omok_win_checker_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [7:0] HMAX = 8'(N - 1);

  logic [1:0]         r_state;
  logic [2*N*N-1:0]   r_board;
  logic [3:0]         r_h, r_v;
  logic [1:0]         r_col;
  logic [1:0]         r_dir;
  logic               r_neg;     // 0: walking +dir, 1: walking -dir
  logic [3:0]         r_s;       // step distance from centre
  logic               r_alive;   // current side still counting
  logic [3:0]         r_pcnt, r_ncnt;
  logic               r_hit;
  logic [1:0]         r_hdir;
  logic               r_busy, r_done, r_win;
  logic [1:0]         r_wcol, r_wdir;

  logic signed [7:0]  w_dh, w_dv, w_ph, w_pv;
  logic               w_on, w_match, w_last, w_hit, w_valid;
  logic [15:0]        w_idx;
  logic [1:0]         w_cell;
  logic [3:0]         w_ncnt_nx, w_run;

  always_comb begin
    w_dh = 8'sd0;
    w_dv = 8'sd0;
    case (r_dir)
      2'd0:    w_dh = 8'sd1;
      2'd1:    w_dv = 8'sd1;
      2'd2:    begin w_dh = 8'sd1; w_dv = 8'sd1;  end
      default: begin w_dh = 8'sd1; w_dv = -8'sd1; end
    endcase
    if (r_neg) begin
      w_dh = -w_dh;
      w_dv = -w_dv;
    end
  end

  // Probe coordinates in signed space so row edges never wrap.
  assign w_ph    = $signed({4'b0, r_h}) + w_dh * $signed({4'b0, r_s});
  assign w_pv    = $signed({4'b0, r_v}) + w_dv * $signed({4'b0, r_s});
  assign w_on    = (w_ph >= 8'sd0) && (w_ph <= HMAX) && (w_pv >= 8'sd0) && (w_pv <= HMAX);
  assign w_idx   = {8'b0, w_pv} * 16'(N) + {8'b0, w_ph};
  assign w_cell  = 2'(r_board >> {w_idx, 1'b0});
  assign w_match = r_alive && w_on && (w_cell == r_col);
  assign w_last  = (r_s == 4'(WIN_LEN - 1));

  // Run length including the current (last) negative-side probe.
  assign w_ncnt_nx = r_ncnt + {3'b0, w_match};
  assign w_run     = 4'd1 + r_pcnt + w_ncnt_nx;
  assign w_hit     = (EXACT != 0) ? (w_run == 4'(WIN_LEN)) : (w_run >= 4'(WIN_LEN));

  // Invalid colour or off-board centre can never win.
  assign w_valid = ((r_col == 2'b01) || (r_col == 2'b10)) &&
                   (r_h < 4'(N)) && (r_v < 4'(N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_board <= '0;
      r_h     <= '0;
      r_v     <= '0;
      r_col   <= '0;
      r_dir   <= '0;
      r_neg   <= 1'b0;
      r_s     <= '0;
      r_alive <= 1'b0;
      r_pcnt  <= '0;
      r_ncnt  <= '0;
      r_hit   <= 1'b0;
      r_hdir  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_win   <= 1'b0;
      r_wcol  <= '0;
      r_wdir  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_board <= bus.board;
            r_h     <= bus.pos_h;
            r_v     <= bus.pos_v;
            r_col   <= bus.color;
            r_win   <= 1'b0;
            r_wcol  <= '0;
            r_wdir  <= '0;
            r_busy  <= 1'b1;
            r_dir   <= '0;
            r_neg   <= 1'b0;
            r_s     <= 4'd1;
            r_alive <= 1'b1;
            r_pcnt  <= '0;
            r_ncnt  <= '0;
            r_hit   <= 1'b0;
            r_hdir  <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!r_neg) r_pcnt <= r_pcnt + {3'b0, w_match};
          else        r_ncnt <= w_ncnt_nx;
          r_alive <= w_match;
          if (w_last) begin
            r_s     <= 4'd1;
            r_alive <= 1'b1;
            if (!r_neg) begin
              r_neg <= 1'b1;
            end else begin
              r_neg  <= 1'b0;
              r_pcnt <= '0;
              r_ncnt <= '0;
              if (w_hit && !r_hit) begin
                r_hit  <= 1'b1;
                r_hdir <= r_dir;
              end
              if (r_dir == 2'd3) r_state <= S_DONE;
              else               r_dir   <= r_dir + 2'd1;
            end
          end else begin
            r_s <= r_s + 4'd1;
          end
        end
        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_win   <= r_hit && w_valid;
          r_wcol  <= (r_hit && w_valid) ? r_col  : 2'b00;
          r_wdir  <= (r_hit && w_valid) ? r_hdir : 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.win       = r_win;
  assign bus.win_color = r_wcol;
  assign bus.win_dir   = r_wdir;
endmodule

// File: tb/tb_omok_win_checker.sv
module tb_omok_win_checker;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [3:0]       ph = '0, pv = '0;
  logic [1:0]       col = '0;
  logic [2*N*N-1:0] brd = '0;

  int errs = 0;
  int checks = 0;

  omok_win_checker_if #(.N(N)) bus0 ();
  omok_win_checker_if #(.N(N)) bus1 ();

  assign bus0.start = start; assign bus1.start = start;
  assign bus0.pos_h = ph;    assign bus1.pos_h = ph;
  assign bus0.pos_v = pv;    assign bus1.pos_v = pv;
  assign bus0.color = col;   assign bus1.color = col;
  assign bus0.board = brd;   assign bus1.board = brd;

  omok_win_checker #(.N(N), .WIN_LEN(5), .EXACT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  omok_win_checker #(.N(N), .WIN_LEN(5), .EXACT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setc(input int h, input int v, input logic [1:0] c);
    brd[2*(v*N+h) +: 2] = c;
  endtask

  // Pulse start for the capture edge; returns #1 after that edge.
  task automatic put(input logic [3:0] h, input logic [3:0] v, input logic [1:0] c);
    @(negedge clk);
    start = 1'b1; ph = h; pv = v; col = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Latency in edges after capture (-1 on timeout); counts busy samples before done.
  task automatic wait_done(output int lat, output int nbusy);
    lat = -1; nbusy = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (bus0.done) begin lat = i; break; end
      if (bus0.busy) nbusy++;
    end
  endtask

  int lat, nbusy, ndone, flat;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_done", 32'(bus0.done), 0);
    chk("rst_win",  32'({bus0.win, bus0.win_color, bus0.win_dir}), 0);
    rst = 1'b1;

    // T1 horizontal five
    brd = '0;
    for (int h = 2; h <= 6; h++) setc(h, 3, 2'b01);
    put(4, 3, 2'b01);
    chk("t1_busy_cap", 32'(bus0.busy), 1);
    wait_done(lat, nbusy);
    chk("t1_lat", 32'(lat), 33);
    chk("t1_nbusy", 32'(nbusy), 32);
    chk("t1_busy_done", 32'(bus0.busy), 0);
    chk("t1_win", 32'(bus0.win), 1);
    chk("t1_col", 32'(bus0.win_color), 32'h1);
    chk("t1_dir", 32'(bus0.win_dir), 0);
    chk("t1_exact_win", 32'(bus1.win), 1);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(bus0.done), 0);
    chk("t1_win_held", 32'(bus0.win), 1);

    // T2 four only
    brd = '0;
    for (int h = 2; h <= 5; h++) setc(h, 3, 2'b01);
    put(5, 3, 2'b01);
    chk("t2_win_cleared", 32'(bus0.win), 0);
    wait_done(lat, nbusy);
    chk("t2_lat", 32'(lat), 33);
    chk("t2_win", 32'({bus0.win, bus0.win_color, bus0.win_dir}), 0);

    // T3 overline
    brd = '0;
    for (int h = 1; h <= 6; h++) setc(h, 7, 2'b01);
    put(3, 7, 2'b01);
    wait_done(lat, nbusy);
    chk("t3_free_win", 32'({bus0.win, bus0.win_color, bus0.win_dir}), 32'b1_01_00);
    chk("t3_exact_win", 32'({bus1.win, bus1.win_color, bus1.win_dir}), 0);

    // T4 no row wrap
    brd = '0;
    for (int h = 7; h <= 9; h++) setc(h, 0, 2'b10);
    setc(0, 1, 2'b10); setc(1, 1, 2'b10);
    put(9, 0, 2'b10);
    wait_done(lat, nbusy);
    chk("t4_nowrap", 32'(bus0.win), 0);

    // T5 anti-diagonal
    brd = '0;
    for (int i = 0; i < 5; i++) setc(2 + i, 6 - i, 2'b10);
    put(6, 2, 2'b10);
    wait_done(lat, nbusy);
    chk("t5_anti", 32'({bus0.win, bus0.win_color, bus0.win_dir}), 32'b1_10_11);
    chk("t5_anti_exact", 32'({bus1.win, bus1.win_dir}), 32'b1_11);

    // Vertical at the bottom-left corner
    brd = '0;
    for (int v = 5; v <= 9; v++) setc(0, v, 2'b01);
    put(0, 9, 2'b01);
    wait_done(lat, nbusy);
    chk("vert_corner", 32'({bus0.win, bus0.win_color, bus0.win_dir}), 32'b1_01_01);

    // Horizontal and vertical both five: lowest dir reported
    brd = '0;
    for (int i = 0; i < 5; i++) begin setc(3 + i, 5, 2'b10); setc(5, 3 + i, 2'b10); end
    put(5, 5, 2'b10);
    wait_done(lat, nbusy);
    chk("lowest_dir", 32'({bus0.win, bus0.win_dir}), 32'b1_00);

    // Invalid colour 11 on a line of 11 cells
    brd = '0;
    for (int h = 0; h <= 4; h++) setc(h, 0, 2'b11);
    put(2, 0, 2'b11);
    wait_done(lat, nbusy);
    chk("bad_col_lat", 32'(lat), 33);
    chk("bad_col_win", 32'({bus0.win, bus0.win_color}), 0);

    // Off-board centre
    brd = '0;
    for (int h = 5; h <= 9; h++) setc(h, 3, 2'b01);
    put(12, 3, 2'b01);
    wait_done(lat, nbusy);
    chk("offboard_win", 32'(bus0.win), 0);

    // T6: re-start ignored, board change ignored
    brd = '0;
    for (int h = 2; h <= 6; h++) setc(h, 3, 2'b01);
    put(4, 3, 2'b01);
    ndone = 0; flat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 5)  brd = '0;
      if (i == 10) begin start = 1'b1; ph = 0; pv = 0; col = 2'b10; end
      if (i == 11) start = 1'b0;
      if (bus0.done) begin
        ndone++;
        if (flat < 0) flat = i;
        chk("t6_win", 32'({bus0.win, bus0.win_color, bus0.win_dir}), 32'b1_01_00);
      end
    end
    chk("t6_ndone", 32'(ndone), 1);
    chk("t6_lat", 32'(flat), 33);

    // T6: reset mid-scan
    for (int h = 2; h <= 6; h++) setc(h, 3, 2'b01);
    put(4, 3, 2'b01);
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_out", 32'({bus0.busy, bus0.done, bus0.win, bus0.win_color, bus0.win_dir}), 0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus0.done || bus0.busy) ndone++;
    end
    chk("t6_rst_quiet", 32'(ndone), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
